// File: rtl/piradspi_engine.sv
// SPI shift/timing engine: per-command mode, length, bit order and divider,
// with programmable chip-select setup/hold and one-hot or binary select.
//
// state   | meaning
// S_IDLE  | cmd_ready high, waiting for a command
// S_SETUP | select asserted, sclk parked at cpol, first mosi bit presented
// S_SHIFT | sclk toggling, one toggle per half-period
// S_HOLD  | last edge done, select still asserted
// S_RESP  | rsp_valid high until rsp_ready
module piradspi_engine #(
  parameter int SEL_MODE  = 0,
  parameter int SEL_WIDTH = 5,
  parameter int MAX_BITS  = 32,
  parameter int DIV_WIDTH = 8,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [MAX_BITS-1:0]         cmd_data,
  input  logic [$clog2(MAX_BITS)-1:0] cmd_nbits_m1,
  input  logic                        cmd_cpol,
  input  logic                        cmd_cpha,
  input  logic                        cmd_lsb_first,
  input  logic [DIV_WIDTH-1:0]        cmd_div,
  input  logic [SEL_WIDTH-1:0]        cmd_dev,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [MAX_BITS-1:0]         rsp_data,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso,
  output logic [SEL_WIDTH-1:0]        csn,
  output logic                        csn_active,
  output logic                        busy
);
  localparam int BW = $clog2(MAX_BITS);
  localparam int EW = BW + 1;
  localparam int TW = (DIV_WIDTH > 16) ? DIV_WIDTH : 16;
  localparam logic [SEL_WIDTH-1:0] CSN_IDLE = (SEL_MODE == 0) ? {SEL_WIDTH{1'b1}} : {SEL_WIDTH{1'b0}};

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_RESP} state_t;
  state_t r_state, w_state_nxt;

  logic [MAX_BITS-1:0]  r_tx, r_rx, r_rsp_data;
  logic [BW-1:0]        r_nbits_m1;
  logic                 r_cpol, r_cpha, r_lsb;
  logic [DIV_WIDTH-1:0] r_div;
  logic [SEL_WIDTH-1:0] r_dev, r_csn;
  logic [TW-1:0]        r_tmr;
  logic [EW-1:0]        r_edge;
  logic                 r_ready, r_busy, r_rsp_valid, r_sclk, r_mosi, r_csn_act;

  logic                 w_accept, w_tmr_zero, w_lead, w_last_edge, w_sample, w_advance;
  logic [BW-1:0]        w_bit, w_bit_nx, w_idx_cur, w_idx_nxt, w_idx_first, w_adv_idx;
  logic [SEL_WIDTH-1:0] w_csn_sel;

  assign w_accept    = cmd_valid & r_ready;
  assign w_tmr_zero  = (r_tmr == '0);
  assign w_lead      = ~r_edge[0];
  assign w_bit       = r_edge[BW:1];
  assign w_bit_nx    = w_bit + 1'b1;
  assign w_last_edge = (r_edge == {r_nbits_m1, 1'b1});
  assign w_idx_cur   = r_lsb ? w_bit : (r_nbits_m1 - w_bit);
  assign w_idx_nxt   = r_lsb ? w_bit_nx : (r_nbits_m1 - w_bit_nx);
  assign w_idx_first = r_lsb ? {BW{1'b0}} : r_nbits_m1;
  // cpha=1 presents bit b on leading edge b; cpha=0 presents bit b+1 on trailing edge b
  assign w_adv_idx   = r_cpha ? w_idx_cur : w_idx_nxt;
  assign w_sample    = (r_state == S_SHIFT) & w_tmr_zero & (r_cpha ? ~w_lead : w_lead);
  assign w_advance   = (r_state == S_SHIFT) & w_tmr_zero &
                       (r_cpha ? (w_lead & (w_bit != '0)) : (~w_lead & (w_bit != r_nbits_m1)));

  always_comb begin
    w_csn_sel = CSN_IDLE;
    if (SEL_MODE == 0) begin
      for (int i = 0; i < SEL_WIDTH; i++)
        if (r_dev == SEL_WIDTH'(i)) w_csn_sel[i] = 1'b0;
    end else begin
      w_csn_sel = r_dev;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP: if (w_tmr_zero) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_tmr_zero && w_last_edge) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_tmr_zero) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tx        <= '0;
      r_rx        <= '0;
      r_rsp_data  <= '0;
      r_nbits_m1  <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsb       <= 1'b0;
      r_div       <= '0;
      r_dev       <= '0;
      r_csn       <= CSN_IDLE;
      r_csn_act   <= 1'b1;
      r_tmr       <= '0;
      r_edge      <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx       <= cmd_data;
            r_rx       <= '0;
            r_nbits_m1 <= cmd_nbits_m1;
            r_cpol     <= cmd_cpol;
            r_cpha     <= cmd_cpha;
            r_lsb      <= cmd_lsb_first;
            r_div      <= cmd_div;
            r_dev      <= cmd_dev;
            // one extra count: select goes out on the first SETUP edge
            r_tmr      <= TW'(CS_SETUP);
          end
        end
        S_SETUP: begin
          r_csn     <= w_csn_sel;
          r_csn_act <= (SEL_MODE == 0) ? (&w_csn_sel) : 1'b0;
          r_sclk    <= r_cpol;
          r_mosi    <= r_tx[w_idx_first];
          if (w_tmr_zero) begin
            r_tmr  <= TW'(r_div);
            r_edge <= '0;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_tmr_zero) begin
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 1'b1;
            r_tmr  <= w_last_edge ? TW'(CS_HOLD - 1) : TW'(r_div);
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
          if (w_sample)  r_rx[w_idx_cur] <= miso;
          if (w_advance) r_mosi <= r_tx[w_adv_idx];
        end
        S_HOLD: begin
          if (w_tmr_zero) begin
            r_csn       <= CSN_IDLE;
            r_csn_act   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rx;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_RESP: if (rsp_ready) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign cmd_ready  = r_ready;
  assign busy       = r_busy;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign sclk       = r_sclk;
  assign mosi       = r_mosi;
  assign csn        = r_csn;
  assign csn_active = r_csn_act;
endmodule

// File: tb/tb_piradspi_engine.sv
// Directed bench for piradspi_engine: one-hot instance driven from a vector
// table, binary-select instance and reset/backpressure corners by hand.
module tb_piradspi_engine;
  localparam int SW = 5;
  localparam int MB = 32;
  localparam int DW = 8;

  logic aclk;
  logic aresetn;
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [MB-1:0] cmd_data;
  logic [4:0]    cmd_nbits_m1;
  logic          cmd_cpol, cmd_cpha, cmd_lsb_first, rsp_ready;
  logic [DW-1:0] cmd_div;
  logic [SW-1:0] cmd_dev;
  logic [1:0]    miso_mode;

  logic          cmd_valid0, cmd_ready0, rsp_valid0, sclk0, mosi0, miso0, csn_active0, busy0;
  logic [MB-1:0] rsp_data0;
  logic [SW-1:0] csn0;
  logic          cmd_valid1, cmd_ready1, rsp_valid1, sclk1, mosi1, miso1, csn_active1, busy1;
  logic [MB-1:0] rsp_data1;
  logic [SW-1:0] csn1;

  // 0: loopback, 1: tied high, 2: tied low
  assign miso0 = (miso_mode == 2'd0) ? mosi0 : miso_mode[0];
  assign miso1 = mosi1;

  piradspi_engine #(.SEL_MODE(0), .SEL_WIDTH(SW), .MAX_BITS(MB), .DIV_WIDTH(DW),
                    .CS_SETUP(2), .CS_HOLD(2)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_data(cmd_data), .cmd_nbits_m1(cmd_nbits_m1), .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha),
    .cmd_lsb_first(cmd_lsb_first), .cmd_div(cmd_div), .cmd_dev(cmd_dev),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .csn(csn0), .csn_active(csn_active0), .busy(busy0));

  piradspi_engine #(.SEL_MODE(1), .SEL_WIDTH(SW), .MAX_BITS(MB), .DIV_WIDTH(DW),
                    .CS_SETUP(2), .CS_HOLD(2)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_data(cmd_data), .cmd_nbits_m1(cmd_nbits_m1), .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha),
    .cmd_lsb_first(cmd_lsb_first), .cmd_div(cmd_div), .cmd_dev(cmd_dev),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1), .csn(csn1), .csn_active(csn_active1), .busy(busy1));

  typedef struct {
    logic [31:0] data;
    logic [4:0]  m1;
    logic        cpol, cpha, lsb;
    logic [7:0]  div;
    logic [4:0]  dev;
    logic [1:0]  mm;
    logic [31:0] exp_rsp;
    logic [4:0]  exp_csn;
    logic        exp_mosi;
    int          exp_lat;
    int          exp_tog;
  } vec_t;

  vec_t vecs[7];
  vec_t vr;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_data = v.data; cmd_nbits_m1 = v.m1; cmd_cpol = v.cpol; cmd_cpha = v.cpha;
    cmd_lsb_first = v.lsb; cmd_div = v.div; cmd_dev = v.dev; miso_mode = v.mm;
  endtask

  // returns just after the accept edge
  task automatic issue0(input vec_t v);
    int n = 0;
    @(negedge aclk);
    drive(v);
    cmd_valid0 = 1'b1;
    while (!cmd_ready0 && n < 200) begin @(negedge aclk); n++; end
    chk("accept_wait", 32'(n < 200), 32'd1);
    @(posedge aclk);
    #1 cmd_valid0 = 1'b0;
  endtask

  // starts just after the accept edge, returns at the negedge where rsp_valid is seen
  task automatic measure0(input vec_t v, input int idx);
    int k = 1;
    int tog = 0;
    logic prev;
    @(posedge aclk);
    @(negedge aclk);
    chk($sformatf("v%0d_csn", idx), 32'(csn0), 32'(v.exp_csn));
    chk($sformatf("v%0d_sclk_idle", idx), 32'(sclk0), 32'(v.cpol));
    chk($sformatf("v%0d_first_mosi", idx), 32'(mosi0), 32'(v.exp_mosi));
    prev = sclk0;
    while (!rsp_valid0 && k < 3000) begin
      @(negedge aclk);
      k++;
      if (sclk0 !== prev) tog++;
      prev = sclk0;
    end
    chk($sformatf("v%0d_latency", idx), 32'(k), 32'(v.exp_lat));
    chk($sformatf("v%0d_toggles", idx), 32'(tog), 32'(v.exp_tog));
    chk($sformatf("v%0d_rsp_data", idx), rsp_data0, v.exp_rsp);
    chk($sformatf("v%0d_sclk_end", idx), 32'(sclk0), 32'(v.cpol));
    chk($sformatf("v%0d_csn_end", idx), 32'(csn0), 32'h1F);
  endtask

  task automatic handshake0(input int idx);
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1 rsp_ready = 1'b0;
    @(negedge aclk);
    chk($sformatf("v%0d_rsp_drop", idx), 32'(rsp_valid0), 32'd0);
    chk($sformatf("v%0d_ready_back", idx), 32'(cmd_ready0), 32'd1);
    chk($sformatf("v%0d_busy_off", idx), 32'(busy0), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, act, badsel;
    // data m1 cpol cpha lsb div dev mm exp_rsp exp_csn mosi lat tog
    vecs[0] = '{32'h0000_00A5, 5'd7,  1'b0, 1'b0, 1'b0, 8'd1, 5'd2, 2'd0, 32'h0000_00A5, 5'b11011, 1'b1, 37, 16};
    vecs[1] = '{32'h0000_03C1, 5'd11, 1'b1, 1'b1, 1'b1, 8'd2, 5'd0, 2'd1, 32'h0000_0FFF, 5'b11110, 1'b1, 77, 24};
    vecs[2] = '{32'h0000_0001, 5'd0,  1'b0, 1'b0, 1'b0, 8'd0, 5'd4, 2'd0, 32'h0000_0001, 5'b01111, 1'b1, 7,  2};
    vecs[3] = '{32'h0000_0000, 5'd0,  1'b0, 1'b1, 1'b0, 8'd0, 5'd1, 2'd1, 32'h0000_0001, 5'b11101, 1'b0, 7,  2};
    vecs[4] = '{32'h0000_005A, 5'd7,  1'b1, 1'b0, 1'b1, 8'd0, 5'd7, 2'd0, 32'h0000_005A, 5'b11111, 1'b0, 21, 16};
    vecs[5] = '{32'hFFFF_FF35, 5'd5,  1'b0, 1'b1, 1'b0, 8'd0, 5'd3, 2'd0, 32'h0000_0035, 5'b10111, 1'b1, 17, 12};
    vecs[6] = '{32'h0000_00FF, 5'd3,  1'b0, 1'b0, 1'b0, 8'd3, 5'd1, 2'd2, 32'h0000_0000, 5'b11101, 1'b1, 37, 8};
    vr      = '{32'h0000_1234, 5'd15, 1'b0, 1'b0, 1'b0, 8'd1, 5'd0, 2'd0, 32'h0000_1234, 5'b11110, 1'b0, 69, 32};

    aresetn = 1'b0; cmd_valid0 = 1'b0; cmd_valid1 = 1'b0; rsp_ready = 1'b0;
    drive(vecs[0]);
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready0), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    chk("rst_rsp_data", rsp_data0, 32'd0);
    chk("rst_sclk", 32'(sclk0), 32'd0);
    chk("rst_mosi", 32'(mosi0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_csn_m0", 32'(csn0), 32'h1F);
    chk("rst_csn_m1", 32'(csn1), 32'h00);
    chk("rst_csn_act_m0", 32'(csn_active0), 32'd1);
    chk("rst_csn_act_m1", 32'(csn_active1), 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("rel_ready_low", 32'(cmd_ready0), 32'd0);
    @(negedge aclk);
    chk("rel_ready_m0", 32'(cmd_ready0), 32'd1);
    chk("rel_ready_m1", 32'(cmd_ready1), 32'd1);

    for (int i = 0; i < 7; i++) begin
      issue0(vecs[i]);
      measure0(vecs[i], i);
      handshake0(i);
    end

    // response backpressure with a command already waiting
    issue0(vecs[0]);
    measure0(vecs[0], 10);
    drive(vecs[5]);
    cmd_valid0 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      chk("bp_rsp_valid", 32'(rsp_valid0), 32'd1);
      chk("bp_rsp_data", rsp_data0, 32'h0000_00A5);
      chk("bp_cmd_ready", 32'(cmd_ready0), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1 rsp_ready = 1'b0;
    @(negedge aclk);
    chk("bp_rsp_drop", 32'(rsp_valid0), 32'd0);
    chk("bp_idle_after_hs", 32'(busy0), 32'd0);
    @(posedge aclk);
    #1 cmd_valid0 = 1'b0;
    chk("bp_next_accepted", 32'(busy0), 32'd1);
    measure0(vecs[5], 11);
    handshake0(11);

    // reset during bit 5 of a 16-bit transfer
    issue0(vr);
    repeat (26) @(posedge aclk);
    #1 chk("mid_csn_selected", 32'(csn0), 32'h1E);
    chk("mid_sclk_high", 32'(sclk0), 32'd1);
    #1 aresetn = 1'b0;
    #1;
    chk("abort_csn", 32'(csn0), 32'h1F);
    chk("abort_csn_act", 32'(csn_active0), 32'd1);
    chk("abort_sclk", 32'(sclk0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid0), 32'd0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("abort_ready_low", 32'(cmd_ready0), 32'd0);
    @(negedge aclk);
    chk("abort_ready_first_edge", 32'(cmd_ready0), 32'd1);
    chk("abort_no_rsp", 32'(rsp_valid0), 32'd0);
    issue0(vr);
    measure0(vr, 20);
    handshake0(20);

    // binary select, 32 bits, div 0
    @(negedge aclk);
    drive('{32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b0, 8'd0, 5'd19, 2'd0, 32'hDEAD_BEEF, 5'd19, 1'b1, 69, 64});
    cmd_valid1 = 1'b1;
    lat = 0;
    while (!cmd_ready1 && lat < 200) begin @(negedge aclk); lat++; end
    chk("m1_accept_wait", 32'(lat < 200), 32'd1);
    @(posedge aclk);
    #1 cmd_valid1 = 1'b0;
    lat = 0; act = 0; badsel = 0;
    @(negedge aclk);
    while (!rsp_valid1 && lat < 3000) begin
      @(negedge aclk);
      lat++;
      if (!csn_active1) begin
        act++;
        if (csn1 !== 5'd19) badsel++;
      end
    end
    chk("m1_latency", 32'(lat), 32'd69);
    chk("m1_active_cycles", 32'(act), 32'd68);
    chk("m1_sel_value", 32'(badsel), 32'd0);
    chk("m1_rsp_data", rsp_data1, 32'hDEAD_BEEF);
    chk("m1_csn_end", 32'(csn1), 32'd0);
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1 rsp_ready = 1'b0;
    @(negedge aclk);
    chk("m1_rsp_drop", 32'(rsp_valid1), 32'd0);
    chk("m1_ready_back", 32'(cmd_ready1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piradspi_engine.md
Name: piradspi_engine

Overview:
- Parametrised SPI transfer engine: the shift/timing core behind the PiRadSPI CSR front end, generalising the fixed single-mode controller.
- Per-command CPOL/CPHA, bit count (1..MAX_BITS), MSB/LSB order, clock divider and target device.
- Programmable CS setup/hold times; one-hot or binary-encoded chip select.
- Command in and response out over valid/ready; the CSR/profile logic drives the command side.

Parameters:
- SEL_MODE, 0: 0 = one-hot active-low csn, one bit per device; 1 = binary device index on csn plus active-low csn_active strobe.
- SEL_WIDTH, 5: width of csn. Device count is SEL_WIDTH (mode 0) or 2**SEL_WIDTH (mode 1).
- MAX_BITS, 32: maximum bits per transfer; width of data paths.
- DIV_WIDTH, 8: width of the divider field.
- CS_SETUP, 2: aclk cycles from csn assert to first SCLK edge (min 1).
- CS_HOLD, 2: aclk cycles from last SCLK edge to csn deassert (min 1).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  engine accepts a command
- cmd_data  in  MAX_BITS  tx word, right-aligned
- cmd_nbits_m1  in  $clog2(MAX_BITS)  bit count minus 1
- cmd_cpol  in  1  SCLK idle level
- cmd_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
- cmd_lsb_first  in  1  bit order
- cmd_div  in  DIV_WIDTH  SCLK half-period minus 1, in aclk cycles
- cmd_dev  in  SEL_WIDTH  target device index
- rsp_valid  out  1  received word valid
- rsp_ready  in  1  response consumed
- rsp_data  out  MAX_BITS  rx word, right-aligned, upper bits zero
- sclk  out  1  SPI clock
- mosi  out  1  SPI data out
- miso  in  1  SPI data in (already synchronised)
- csn  out  SEL_WIDTH  chip select(s)
- csn_active  out  1  active-low select strobe (SEL_MODE 1); mirrors AND of csn in mode 0
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, all outputs registered):
  - State IDLE; cmd_ready 0, rising to 1 on the first aclk edge after release.
  - rsp_valid 0, rsp_data 0, sclk 0, mosi 0, busy 0.
  - csn all-ones (mode 0) or all-zeros (mode 1); csn_active 1.
- Reset mid-transfer aborts immediately: no response is produced and csn deasserts asynchronously.
- FSM states: IDLE, SETUP, SHIFT, HOLD, RESP.
- IDLE: cmd_ready=1. Accept on edge T0 where cmd_valid&cmd_ready; latch all cmd_* fields.
- SETUP (edge T0+1):
  - Select: csn[cmd_dev]=0 (mode 0) or csn=cmd_dev with csn_active=0 (mode 1).
  - sclk=cpol; mosi = first bit (bit nbits_m1 if MSB-first, else bit 0).
  - Lasts CS_SETUP cycles.
- SHIFT:
  - 2*(nbits_m1+1) half-periods, each cmd_div+1 cycles; sclk toggles at each half-period boundary.
  - CPHA=0: miso sampled on leading (odd) edges; mosi advances on trailing edges, except after the final trailing edge.
  - CPHA=1: mosi advances on leading edges, except the first, whose bit is already presented in SETUP; miso sampled on trailing edges.
  - sclk ends at cpol.
- HOLD: sclk=cpol, select still asserted, CS_HOLD cycles.
- HOLD exit: deselect, rsp_valid=1, rsp_data loaded, state RESP.
  - rsp_valid first high at T0 + 1 + CS_SETUP + 2*(nbits_m1+1)*(cmd_div+1) + CS_HOLD.
- RESP: hold rsp_valid/rsp_data stable until rsp_ready; then rsp_valid=0 and IDLE (cmd_ready=1) on the same edge. No command accepted while rsp_valid=1.
- rx assembly:
  - MSB-first: first sampled bit lands at bit nbits_m1.
  - LSB-first: first sampled bit lands at bit 0.
  - Bits above nbits_m1 are 0.
- Between transfers, sclk holds the last latched cpol; mosi holds its last value.
- Device index out of range (mode 0, cmd_dev >= SEL_WIDTH): transfer runs with all csn high; response still returned.
- cmd_div=0: half-period of 1 cycle, SCLK = aclk/2.
- cmd_nbits_m1=0: single-bit transfer.

Test Plan:
- Mode 0, cpol0 cpha0 MSB, 8 bits, data 0xA5, div 1, dev 2, miso loops to mosi -> csn=5'b11011 during transfer, 8 sclk pulses of 4-cycle period, rsp_data=0x000000A5, rsp_valid exactly 2+32+2+1=37 cycles after accept.
- cpol1 cpha1 LSB-first, 12 bits, data 0x3C1, miso tied 1 -> sclk idles high, first mosi bit 1, rsp_data=0x00000FFF.
- SEL_MODE 1, dev 19, 32 bits, div 0, data 0xDEADBEEF, loopback -> csn=5'd19 with csn_active=0 for exactly CS_SETUP+64+CS_HOLD cycles, rsp_data=0xDEADBEEF.
- rsp_ready held 0 for 10 cycles with cmd_valid high -> rsp_valid/rsp_data stable, cmd_ready 0, next command accepted only after the rsp handshake edge.
- aresetn pulsed low mid-SHIFT (bit 5 of 16) -> csn deasserts and sclk=0 immediately, rsp_valid never rises, cmd_ready=1 on the first edge after release, a new transfer completes normally.
- Back-to-back 1-bit transfers, cpha0 then cpha1 -> correct sampled bit each, one sclk pulse each, no extra edges.
